// File: rtl/ps2_pkg.sv
// Shared types and frame constants for the PS/2 device-to-host receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_BITS = 8;

    // A frame is accepted when the stop bit is high and byte plus parity hold an odd count of ones.
    function automatic logic frame_ok(input logic [7:0] byte_in, input logic parity_in,
                                      input logic stop_in);
        return (stop_in == STOP_BIT) && (^{byte_in, parity_in});
    endfunction

endpackage

// File: rtl/ps2_filter.sv
// Two-flop synchroniser, glitch filter and falling-edge pulse for the raw PS/2 clock pin.
module ps2_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_in,
    output logic level,
    output logic fall
);

    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_fall;
    logic [CNT_W-1:0] r_cnt;

    // Synchronise, then let the filtered level follow only after FILTER_LEN differing samples in a row.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b1;
            r_fall  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= raw_in;
            r_sync2 <= r_sync1;
            r_fall  <= 1'b0;
            if (r_sync2 != r_level) begin
                if (r_cnt == CNT_LAST) begin
                    r_level <= r_sync2;
                    r_fall  <= ~r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign level = r_level;
    assign fall  = r_fall;

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver: start, 8 data bits LSB first, odd parity, stop.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] data,
    output logic       ready,
    output logic       err,
    output logic       busy
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    logic            w_fclk_unused;
    logic            w_fall;
    logic            r_dat_s1;
    logic            r_dat_s2;
    state_t          r_state;
    state_t          w_state_next;
    logic            w_ready_next;
    logic            w_err_next;
    logic            r_ready;
    logic            r_err;
    logic            r_busy;
    logic [7:0]      r_shift;
    logic [2:0]      r_bitcnt;
    logic            r_parity;
    logic [TO_W-1:0] r_tocnt;
    logic [7:0]      r_data;

    ps2_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clk_filter (
        .clock (clock),
        .reset (reset),
        .raw_in(ps2_clk),
        .level (w_fclk_unused),
        .fall  (w_fall)
    );

    // Data pin only needs synchronising; it is sampled long after it settles in the bit cell.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_dat_s1 <= ps2_dat;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // Next-state and strobe decode; a timeout only fires when no edge arrives in the same cycle.
    always_comb begin
        w_state_next = r_state;
        w_ready_next = 1'b0;
        w_err_next   = 1'b0;
        case (r_state)
            IDLE:   if (w_fall && (r_dat_s2 == START_BIT)) w_state_next = DATA;
            DATA:   if (w_fall && (r_bitcnt == LAST_BIT)) w_state_next = PARITY;
            PARITY: if (w_fall) w_state_next = STOP;
            STOP: begin
                if (w_fall) begin
                    w_state_next = IDLE;
                    if (frame_ok(r_shift, r_parity, r_dat_s2)) w_ready_next = 1'b1;
                    else                                       w_err_next   = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
        if ((r_state != IDLE) && !w_fall && (r_tocnt == TO_LAST)) begin
            w_state_next = IDLE;
            w_ready_next = 1'b0;
            w_err_next   = 1'b1;
        end
    end

    // State register with the registered strobes and busy flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ready <= w_ready_next;
            r_err   <= w_err_next;
            r_busy  <= (w_state_next != IDLE);
        end
    end

    // Shift register, bit/timeout counters and the held output byte.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_parity <= 1'b0;
            r_tocnt  <= '0;
            r_data   <= '0;
        end else begin
            if ((r_state == IDLE) || w_fall) r_tocnt <= '0;
            else                             r_tocnt <= r_tocnt + TO_W'(1);
            if (w_fall) begin
                case (r_state)
                    IDLE: r_bitcnt <= '0;
                    DATA: begin
                        r_shift  <= {r_dat_s2, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 3'd1;
                    end
                    PARITY:  r_parity <= r_dat_s2;
                    default: ;
                endcase
            end
            if (w_ready_next) r_data <= r_shift;
        end
    end

    assign data  = r_data;
    assign ready = r_ready;
    assign err   = r_err;
    assign busy  = r_busy;

endmodule
